// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional borrow-in port is enabled by SERIAL_SUBTRACTOR_BORROW_IN_EN.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin.
// equal is the borrow-propagate term (x ~^ y).
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout,
  output logic equal
);

  assign equal = x ~^ y;
  assign d     = x ^ y ^ bin;
  assign bout  = (~x & y) | (equal & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per cycle.
// Define SERIAL_SUBTRACTOR_BORROW_IN_EN to add a borrow_in port for chaining.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_res;
  logic             r_borrow;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bout;
  logic             w_eq;
  logic             w_unused;
  logic             w_bin0;
  logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  assign w_bin0 = borrow_in;
`else
  assign w_bin0 = 1'b0;
`endif

  full_subtractor u_fsub (
    .x     (r_sa[0]),
    .y     (r_sb[0]),
    .bin   (r_borrow),
    .d     (w_d),
    .bout  (w_bout),
    .equal (w_eq)
  );

  assign w_unused   = w_eq;
  assign w_res_next = {w_d, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sa       <= '0;
      r_sb       <= '0;
      r_res      <= '0;
      r_borrow   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= w_bin0;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= b[WIDTH-1];
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= SHIFT;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_res    <= w_res_next[WIDTH-1:1];
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          // Final bit: publish the result on the edge entering DONE.
          if (r_cnt == LAST) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= w_res_next;
            borrow_out <= w_bout;
            overflow   <= (r_sign_a ^ r_sign_b) & (w_d ^ r_sign_a);
            zero       <= ~|w_res_next;
            r_state    <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; the inverse-direction counterpart of the team's combinational full-adder cell.
- Computes DIFF = A - B one bit per cycle, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Used in area-constrained datapaths where a WIDTH-bit ripple subtractor is too large.
- Start/busy/done handshake toward the issuing controller.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; operands sampled on the same edge when accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  A - B modulo 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow (1 when A < B unsigned).
- overflow  output  1  signed overflow: sign(A) != sign(B) and sign(diff) != sign(A).
- zero  output  1  diff == 0.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state IDLE; busy, done, borrow_out, overflow, zero = 0; diff = 0; internal shift registers, borrow register and bit counter = 0.
- States:
  - IDLE: start=1 latches a into sreg_a, b into sreg_b and borrow=0; also latches a[WIDTH-1] and b[WIDTH-1] for overflow; cnt=0; go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: busy=1.
    - Each cycle: d = sreg_a[0]^sreg_b[0]^borrow; bnext = (~sreg_a[0] & sreg_b[0]) | (~(sreg_a[0]^sreg_b[0]) & borrow).
    - d shifts into sreg_res MSB; sreg_a and sreg_b shift right; borrow <= bnext; cnt++.
    - When cnt == WIDTH-1: go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - diff, borrow_out, overflow and zero update on the edge entering DONE.
    - Next state is IDLE, or SHIFT if start=1 in this cycle; back-to-back operation is allowed.
- Latency: start accepted at edge N; done high during the cycle after edge N+WIDTH; results readable in that cycle.
- Throughput: one result per WIDTH+1 cycles when start is held high.
- start during SHIFT is ignored; operands are not re-sampled.
- a and b are don't-care except on an accepted start edge.
- Outputs diff, borrow_out, overflow and zero are stable between DONE pulses.
- rst in any state, including mid-SHIFT, aborts the operation. Everything returns to reset values on that edge, and no done pulse is produced for the aborted operation.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_BORROW_IN_EN.
- Defined:
  - Adds input borrow_in (1 bit), sampled with start as the initial borrow. This allows multi-word chaining by feeding a previous borrow_out.
  - Result is A - B - borrow_in.
  - Overflow is computed on the final diff with the same rule.
- Undefined: no port; initial borrow is fixed at 0.

Decomposition:
- Shared package serial_sub_pkg:
  - state typedef enum {IDLE, SHIFT, DONE} (2 bits).
  - default WIDTH constant.
  - counter width function clog2(WIDTH).
- One sub-module: full_subtractor, a combinational 1-bit cell.
  - Inputs: x, y, bin.
  - Outputs: d, bout, and equal (x ~^ y), as the borrow-propagate term.
  - Instantiated once in the SHIFT datapath.

Test Plan (WIDTH=8):
- a=10, b=3, start 1 cycle -> busy for 8 cycles; done 9 cycles after start; diff=0x07, borrow_out=0, overflow=0, zero=0.
- a=3, b=10 -> diff=0xF9, borrow_out=1, overflow=0.
- a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0; a=0x7F, b=0xFF -> diff=0x80, overflow=1.
- a=0x55, b=0x55 -> diff=0x00, zero=1, borrow_out=0.
- Hold start high with new operands (0x20-0x01, then 0x01-0x02) -> results 0x1F then 0xFF (borrow 1). done pulses 9 cycles apart, and start pulses during SHIFT leave the results unchanged.
- Assert rst at SHIFT cycle 4 -> next edge: busy=0, diff=0, no done. A new start then completes normally. With SERIAL_SUBTRACTOR_BORROW_IN_EN defined: a=0, b=0, borrow_in=1 -> diff=0xFF, borrow_out=1.
